// File: rtl/pdm_pkg.sv
// pdm_pkg: constants and helpers shared by the PDM modulator and demodulator.
//   PCM_W / PCM_MAX     PCM sample width and full-scale code
//   CIC_ORDER / CIC_DECIM / CIC_W  decimation filter shape and register width
//   WARMUP_DISCARD      comb results dropped after reset while the filter settles
package pdm_pkg;
    localparam int PCM_W          = 10;
    localparam int PCM_MAX        = 1023;
    localparam int CIC_ORDER      = 2;
    localparam int CIC_DECIM      = 32;
    localparam int CIC_W          = 12;
    localparam int WARMUP_DISCARD = 2;

    localparam int DEC_W  = $clog2(CIC_DECIM);
    localparam int WARM_W = $clog2(WARMUP_DISCARD + 1);

    typedef logic [CIC_W-1:0] cic_t;
    typedef logic [PCM_W-1:0] pcm_t;

    // The filter output peaks at exactly R^2 = 1024, one above the PCM range.
    function automatic pcm_t cic_saturate(input cic_t y);
        return (y >= cic_t'(PCM_MAX + 1)) ? pcm_t'(PCM_MAX) : y[PCM_W-1:0];
    endfunction
endpackage

// File: rtl/pdm_tick_gen.sv
// pdm_tick_gen: bit-rate divider shared by the PDM modulator and demodulator.
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   tick   out  one-cycle pulse every CLK_DIV cycles, on the cycle the
//               counter sits at CLK_DIV-1 (first at cycle CLK_DIV-1)
module pdm_tick_gen #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end
endmodule

// File: rtl/pdm_demodulator.sv
// pdm_demodulator: recovers 10-bit PCM from a 1-bit PDM stream using a
// 2nd-order CIC decimator (R = 32), saturation to 0..1023 and a
// valid/ready output.
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   pdm_in     in   PDM bitstream (1 = full scale)
//   pcm_ready  in   downstream accepts pcm_out this cycle
//   pcm_out    out  decoded sample, 0..1023
//   pcm_valid  out  pcm_out holds an unconsumed sample
//   overrun    out  sticky: a sample was overwritten before acceptance
// Build option PDM_DEMOD_INPUT_SYNC_EN: when defined, pdm_in passes through
// a 2-flop synchronizer before sampling (for an asynchronous off-chip line).
module pdm_demodulator
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_in,
    input  logic             pcm_ready,
    output logic [PCM_W-1:0] pcm_out,
    output logic             pcm_valid,
    output logic             overrun
);
    logic tick;

    pdm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic pdm_bit;

`ifdef PDM_DEMOD_INPUT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], pdm_in};
    end

    assign pdm_bit = sync_q[1];
`else
    assign pdm_bit = pdm_in;
`endif

    cic_t              i1, i2, i2_d, c1_d;
    cic_t              c1, y;
    logic [DEC_W-1:0]  dec_cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic              comb_en, result_vld, xfer;

    // Comb stage reads the integrator values from before this tick's update.
    // 12-bit modular wrap cancels exactly in the differences.
    assign comb_en    = tick && (dec_cnt == DEC_W'(CIC_DECIM - 1));
    assign c1         = i2 - i2_d;
    assign y          = c1 - c1_d;
    assign result_vld = comb_en && (warm_cnt == WARM_W'(WARMUP_DISCARD));
    assign xfer       = pcm_valid && pcm_ready;

    // Integrators, decimation counter and comb delays.
    always_ff @(posedge clk) begin
        if (reset) begin
            i1       <= '0;
            i2       <= '0;
            i2_d     <= '0;
            c1_d     <= '0;
            dec_cnt  <= '0;
            warm_cnt <= '0;
        end else if (tick) begin
            i1      <= i1 + cic_t'(pdm_bit);
            i2      <= i2 + i1;
            // CIC_DECIM is a power of two, so the counter wraps by itself.
            dec_cnt <= dec_cnt + 1'b1;
            if (comb_en) begin
                i2_d <= i2;
                c1_d <= c1;
                if (warm_cnt != WARM_W'(WARMUP_DISCARD))
                    warm_cnt <= warm_cnt + 1'b1;
            end
        end
    end

    // Output register. A new result always wins; it only counts as an
    // overrun when the held sample is not being taken in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (result_vld) begin
            pcm_out   <= cic_saturate(y);
            pcm_valid <= 1'b1;
            if (pcm_valid && !pcm_ready)
                overrun <= 1'b1;
        end else if (xfer) begin
            pcm_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_demodulator.sv
// Testbench for pdm_demodulator. The reference model keeps every sampled PDM
// bit and computes each CIC output as a closed-form triangular-weighted sum.
module tb_pdm_demodulator;
    localparam int D     = 4;
    localparam int SPAN  = 32 * D;
    localparam int FIRST = 96 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pdm_in = 1'b0;
    logic       pcm_ready = 1'b0;
    logic [9:0] pcm_out;
    logic       pcm_valid;
    logic       overrun;

    int tests_run = 0;
    int tests_failed = 0;

    // Stimulus source: 0 = zeros, 1 = ones, 2 = repeating pattern, 3 = random
    int         mode = 0;
    logic [7:0] pat = 8'h0;
    int         plen = 1;

    int nc = 0;
    int ntick = 0;
    bit cur_bit = 1'b0;
    bit xs[$];
    int exp_q[$];

    pdm_demodulator #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .pdm_in    (pdm_in),
        .pcm_ready (pcm_ready),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // i2 seen before tick n: bit k (1-based) has been summed (n-1-k) times.
    function automatic int s_of(int n);
        int acc;
        acc = 0;
        for (int k = 1; k <= n - 2; k++)
            acc += int'(xs[k-1]) * (n - 1 - k);
        return acc;
    endfunction

    function automatic int expect_sample(int n);
        int y;
        y = s_of(n) - 2 * s_of(n - 32) + s_of(n - 64);
        return (y > 1023) ? 1023 : y;
    endfunction

    // Drives pdm_in, holding one bit per tick interval, and queues the
    // expected value of every delivered result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                nc = 0;
                ntick = 0;
                xs.delete();
                exp_q.delete();
            end else begin
                if (nc % D == 0) begin
                    case (mode)
                        0:       cur_bit = 1'b0;
                        1:       cur_bit = 1'b1;
                        2:       cur_bit = pat[(nc / D) % plen];
                        default: cur_bit = bit'($urandom_range(0, 1));
                    endcase
                end
                pdm_in = cur_bit;
                if (nc % D == D - 1) begin
                    xs.push_back(cur_bit);
                    ntick++;
                    if (ntick % 32 == 0 && ntick / 32 >= 3)
                        exp_q.push_back(expect_sample(ntick));
                end
                nc++;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // n = negedges waited until pcm_valid is seen, -1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (pcm_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pop_exp(output int e);
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        mode = 0; pcm_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        tests_run++;
        if (pcm_out !== 10'd0 || pcm_valid !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%0d valid=%b overrun=%b, want 0/0/0", pcm_out, pcm_valid, overrun);
        end
    endtask

    task automatic test_full_scale();
        int n, e;
        mode = 1; pcm_ready = 1'b1;
        apply_reset();
        wait_valid(FIRST + 10, n);
        tests_run++;
        if (n - 1 !== FIRST) begin
            tests_failed++;
            $display("FAIL full_first_valid: cycle=%0d want %0d", n - 1, FIRST);
            return;
        end
        pop_exp(e);
        tests_run++;
        if (int'(pcm_out) !== 1023 || e !== 1023) begin
            tests_failed++;
            $display("FAIL full_first_value: out=%0d model=%0d want 1023", pcm_out, e);
        end
        @(negedge clk);
        tests_run++;
        if (pcm_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_valid_pulse: valid=%b want 0", pcm_valid);
        end
        for (int s = 0; s < 3; s++) begin
            wait_valid(SPAN + 10, n);
            tests_run++;
            if (n !== SPAN - ((s == 0) ? 1 : 0) || int'(pcm_out) !== 1023) begin
                tests_failed++;
                $display("FAIL full_steady: gap=%0d out=%0d want gap %0d out 1023", n, pcm_out, SPAN);
                return;
            end
            pop_exp(e);
        end
    endtask

    task automatic test_zero();
        int n, e;
        mode = 0; pcm_ready = 1'b1;
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            wait_valid(FIRST + 10, n);
            pop_exp(e);
            tests_run++;
            if (n < 0 || pcm_out !== 10'd0 || overrun !== 1'b0 || e !== 0) begin
                tests_failed++;
                $display("FAIL zero_sample%0d: wait=%0d out=%0d overrun=%b model=%0d want 0", s, n, pcm_out, overrun, e);
                return;
            end
        end
    endtask

    task automatic test_density();
        int n, e, want;
        logic [7:0] pats [3];
        int lens [3];
        int wants [3];
        pats[0] = 8'b0000_0010; lens[0] = 2; wants[0] = 512;
        pats[1] = 8'b0000_0001; lens[1] = 4; wants[1] = 256;
        pats[2] = 8'b0000_1110; lens[2] = 4; wants[2] = 768;
        for (int p = 0; p < 3; p++) begin
            mode = 2; pat = pats[p]; plen = lens[p]; want = wants[p];
            pcm_ready = 1'b1;
            apply_reset();
            for (int s = 0; s < 3; s++) begin
                wait_valid(FIRST + 10, n);
                pop_exp(e);
                tests_run++;
                if (n < 0 || int'(pcm_out) !== want || int'(pcm_out) !== e) begin
                    tests_failed++;
                    $display("FAIL density%0d_sample%0d: out=%0d model=%0d want %0d", p, s, pcm_out, e, want);
                end
            end
        end
    endtask

    task automatic test_random();
        int n, e;
        mode = 3; pcm_ready = 1'b1;
        apply_reset();
        for (int s = 0; s < 8; s++) begin
            wait_valid(FIRST + 10, n);
            pop_exp(e);
            tests_run++;
            if (n < 0 || int'(pcm_out) !== e) begin
                tests_failed++;
                $display("FAIL random_sample%0d: out=%0d want %0d (wait=%0d)", s, pcm_out, e, n);
                return;
            end
        end
    endtask

    task automatic test_backpressure();
        int n, e;
        logic [9:0] held;
        bit stable;
        mode = 3; pcm_ready = 1'b0;
        apply_reset();
        wait_valid(FIRST + 10, n);
        pop_exp(e);
        tests_run++;
        if (n < 0 || int'(pcm_out) !== e) begin
            tests_failed++;
            $display("FAIL bp_first: out=%0d want %0d (wait=%0d)", pcm_out, e, n);
            return;
        end
        held = pcm_out;
        stable = 1'b1;
        for (int i = 1; i < SPAN; i++) begin
            @(negedge clk);
            if (pcm_out !== held || pcm_valid !== 1'b1 || overrun !== 1'b0) stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL bp_hold: out=%0d valid=%b overrun=%b want %0d/1/0", pcm_out, pcm_valid, overrun, held);
        end
        @(negedge clk);
        pop_exp(e);
        tests_run++;
        if (int'(pcm_out) !== e || pcm_valid !== 1'b1 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_overwrite: out=%0d valid=%b overrun=%b want %0d/1/1", pcm_out, pcm_valid, overrun, e);
        end
        @(posedge clk); #1 pcm_ready = 1'b1;
        @(posedge clk); #1 pcm_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (pcm_valid !== 1'b0 || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept: valid=%b overrun=%b want 0/1", pcm_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        int n, e;
        mode = 3; pcm_ready = 1'b0;
        apply_reset();
        wait_valid(FIRST + 10, n);
        pop_exp(e);
        tests_run++;
        if (n < 0 || int'(pcm_out) !== e) begin
            tests_failed++;
            $display("FAIL b2b_first: out=%0d want %0d (wait=%0d)", pcm_out, e, n);
            return;
        end
        repeat (SPAN - 2) @(negedge clk);
        @(posedge clk); #1 pcm_ready = 1'b1;
        @(posedge clk); #1 pcm_ready = 1'b0;
        @(negedge clk);
        pop_exp(e);
        tests_run++;
        if (int'(pcm_out) !== e || pcm_valid !== 1'b1 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_load: out=%0d valid=%b overrun=%b want %0d/1/0", pcm_out, pcm_valid, overrun, e);
        end
        @(negedge clk);
        tests_run++;
        if (pcm_valid !== 1'b1 || int'(pcm_out) !== e) begin
            tests_failed++;
            $display("FAIL b2b_held: out=%0d valid=%b want %0d/1", pcm_out, pcm_valid, e);
        end
    endtask

    task automatic test_reset_midstream();
        int n, e;
        mode = 3; pcm_ready = 1'b0;
        apply_reset();
        wait_valid(FIRST + 10, n);
        tests_run++;
        if (n < 0) begin
            tests_failed++;
            $display("FAIL mid_first: timeout, want valid at %0d", FIRST);
            return;
        end
        repeat (5000) @(negedge clk);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_overrun_before: overrun=%b want 1", overrun);
        end
        apply_reset();
        @(negedge clk);
        tests_run++;
        if (pcm_out !== 10'd0 || pcm_valid !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_clear: out=%0d valid=%b overrun=%b want 0/0/0", pcm_out, pcm_valid, overrun);
        end
        wait_valid(FIRST + 10, n);
        pop_exp(e);
        tests_run++;
        if (n !== FIRST || int'(pcm_out) !== e) begin
            tests_failed++;
            $display("FAIL mid_restart: cycle=%0d out=%0d want cycle %0d out %0d", n, pcm_out, FIRST, e);
        end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_zero();
        test_density();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
